// File: rtl/rs_mul_queue_pkg.sv
// Shared constants for the multiplier reservation station slice.
package rs_mul_queue_pkg;
  localparam int unsigned RV32_DATA_WIDTH = 32;
  localparam int unsigned RRF_ENT_SEL     = 6;
  localparam int unsigned RS_MUL_DEPTH    = 4;
  localparam int unsigned RS_MUL_NUM_FWD  = 3;
endpackage

// File: rtl/rs_mul_queue_if.sv
// Dispatch, broadcast and issue signals of the MUL reservation station.
interface rs_mul_queue_if
  import rs_mul_queue_pkg::*;
#(
  parameter int unsigned DATA_W  = RV32_DATA_WIDTH,
  parameter int unsigned TAG_W   = RRF_ENT_SEL,
  parameter int unsigned NUM_FWD = RS_MUL_NUM_FWD,
  parameter int unsigned CNT_W   = $clog2(RS_MUL_DEPTH + 1)
) ();
  logic                      i_flush;
  logic                      i_dp_vld;
  logic                      o_dp_rdy;
  logic                      i_dp_signed1;
  logic                      i_dp_signed2;
  logic                      i_dp_sel_high;
  logic                      i_dp_rs1_vld;
  logic                      i_dp_rs2_vld;
  logic [DATA_W-1:0]         i_dp_rs1;
  logic [DATA_W-1:0]         i_dp_rs2;
  logic [TAG_W-1:0]          i_dp_rrftag;
  logic [NUM_FWD-1:0]        i_fwd_vld;
  logic [NUM_FWD*TAG_W-1:0]  i_fwd_tag;
  logic [NUM_FWD*DATA_W-1:0] i_fwd_data;
  logic                      o_iss_vld;
  logic                      i_iss_rdy;
  logic                      o_iss_signed1;
  logic                      o_iss_signed2;
  logic                      o_iss_sel_high;
  logic [DATA_W-1:0]         o_iss_rs1;
  logic [DATA_W-1:0]         o_iss_rs2;
  logic [TAG_W-1:0]          o_iss_rrftag;
  logic [CNT_W-1:0]          o_count;

  modport master (
    output i_flush, i_dp_vld, i_dp_signed1, i_dp_signed2, i_dp_sel_high,
           i_dp_rs1_vld, i_dp_rs2_vld, i_dp_rs1, i_dp_rs2, i_dp_rrftag,
           i_fwd_vld, i_fwd_tag, i_fwd_data, i_iss_rdy,
    input  o_dp_rdy, o_iss_vld, o_iss_signed1, o_iss_signed2, o_iss_sel_high,
           o_iss_rs1, o_iss_rs2, o_iss_rrftag, o_count
  );

  modport slave (
    input  i_flush, i_dp_vld, i_dp_signed1, i_dp_signed2, i_dp_sel_high,
           i_dp_rs1_vld, i_dp_rs2_vld, i_dp_rs1, i_dp_rs2, i_dp_rrftag,
           i_fwd_vld, i_fwd_tag, i_fwd_data, i_iss_rdy,
    output o_dp_rdy, o_iss_vld, o_iss_signed1, o_iss_signed2, o_iss_sel_high,
           o_iss_rs1, o_iss_rs2, o_iss_rrftag, o_count
  );
endinterface

// File: rtl/rs_mul_queue_fwd_match.sv
// One operand's tag compare against all broadcast channels; captures data on match.
module rs_fwd_match
  import rs_mul_queue_pkg::*;
#(
  parameter int unsigned DATA_W  = RV32_DATA_WIDTH,
  parameter int unsigned TAG_W   = RRF_ENT_SEL,
  parameter int unsigned NUM_FWD = RS_MUL_NUM_FWD
) (
  input  logic                      vld_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic [NUM_FWD-1:0]        fwd_vld_i,
  input  logic [NUM_FWD*TAG_W-1:0]  fwd_tag_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
  output logic                      vld_o,
  output logic [DATA_W-1:0]         data_o
);
  // Scan from the highest channel down so the lowest matching channel wins.
  always_comb begin
    vld_o  = vld_i;
    data_o = data_i;
    if (!vld_i) begin
      for (int unsigned k = NUM_FWD; k > 0; k--) begin
        if (fwd_vld_i[k-1] && (fwd_tag_i[(k-1)*TAG_W +: TAG_W] == data_i[TAG_W-1:0])) begin
          vld_o  = 1'b1;
          data_o = fwd_data_i[(k-1)*DATA_W +: DATA_W];
        end
      end
    end
  end
endmodule

// File: rtl/rs_mul_queue.sv
// Multi-entry MUL reservation station: dispatch allocate, broadcast wakeup, in-order-of-index issue.
module rs_mul_queue
  import rs_mul_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = RS_MUL_DEPTH,
  parameter int unsigned DATA_W  = RV32_DATA_WIDTH,
  parameter int unsigned TAG_W   = RRF_ENT_SEL,
  parameter int unsigned NUM_FWD = RS_MUL_NUM_FWD,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input logic           clk,
  input logic           rst_n,
  rs_mul_queue_if.slave bus
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  busy_q, busy_d, v1_q, v1_d, v2_q, v2_d;
  logic [DEPTH-1:0]  s1_q, s1_d, s2_q, s2_d, sh_q, sh_d;
  logic [DATA_W-1:0] rs1_q [DEPTH];
  logic [DATA_W-1:0] rs1_d [DEPTH];
  logic [DATA_W-1:0] rs2_q [DEPTH];
  logic [DATA_W-1:0] rs2_d [DEPTH];
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [TAG_W-1:0]  tag_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH-1:0]  wv1, wv2;
  logic [DATA_W-1:0] wd1 [DEPTH];
  logic [DATA_W-1:0] wd2 [DEPTH];
  logic              dv1, dv2;
  logic [DATA_W-1:0] dd1, dd2;

  logic [DEPTH-1:0]  ready;
  logic              iss_any, free_any, iss_fire, dp_fire;
  logic [IDX_W-1:0]  iss_idx, free_idx;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_fwd_match #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_FWD(NUM_FWD)) u_m1 (
      .vld_i(v1_q[g]), .data_i(rs1_q[g]), .fwd_vld_i(bus.i_fwd_vld),
      .fwd_tag_i(bus.i_fwd_tag), .fwd_data_i(bus.i_fwd_data),
      .vld_o(wv1[g]), .data_o(wd1[g]));
    rs_fwd_match #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_FWD(NUM_FWD)) u_m2 (
      .vld_i(v2_q[g]), .data_i(rs2_q[g]), .fwd_vld_i(bus.i_fwd_vld),
      .fwd_tag_i(bus.i_fwd_tag), .fwd_data_i(bus.i_fwd_data),
      .vld_o(wv2[g]), .data_o(wd2[g]));
  end

  rs_fwd_match #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_FWD(NUM_FWD)) u_dp1 (
    .vld_i(bus.i_dp_rs1_vld), .data_i(bus.i_dp_rs1), .fwd_vld_i(bus.i_fwd_vld),
    .fwd_tag_i(bus.i_fwd_tag), .fwd_data_i(bus.i_fwd_data),
    .vld_o(dv1), .data_o(dd1));
  rs_fwd_match #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_FWD(NUM_FWD)) u_dp2 (
    .vld_i(bus.i_dp_rs2_vld), .data_i(bus.i_dp_rs2), .fwd_vld_i(bus.i_fwd_vld),
    .fwd_tag_i(bus.i_fwd_tag), .fwd_data_i(bus.i_fwd_data),
    .vld_o(dv2), .data_o(dd2));

  assign ready = busy_q & v1_q & v2_q;

  // Lowest-index priority encoders for issue and allocation.
  always_comb begin
    iss_any  = 1'b0;
    iss_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (ready[i-1]) begin
        iss_any = 1'b1;
        iss_idx = IDX_W'(i - 1);
      end
      if (!busy_q[i-1]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i - 1);
      end
    end
  end

  assign iss_fire = iss_any & bus.i_iss_rdy & ~bus.i_flush;
  assign dp_fire  = bus.i_dp_vld & free_any & ~bus.i_flush;

  always_comb begin
    bus.o_iss_vld      = iss_any;
    bus.o_iss_signed1  = 1'b0;
    bus.o_iss_signed2  = 1'b0;
    bus.o_iss_sel_high = 1'b0;
    bus.o_iss_rs1      = '0;
    bus.o_iss_rs2      = '0;
    bus.o_iss_rrftag   = '0;
    if (iss_any) begin
      bus.o_iss_signed1  = s1_q[iss_idx];
      bus.o_iss_signed2  = s2_q[iss_idx];
      bus.o_iss_sel_high = sh_q[iss_idx];
      bus.o_iss_rs1      = rs1_q[iss_idx];
      bus.o_iss_rs2      = rs2_q[iss_idx];
      bus.o_iss_rrftag   = tag_q[iss_idx];
    end
  end

  assign bus.o_dp_rdy = free_any;
  assign bus.o_count  = count_q;

  always_comb begin
    busy_d = busy_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    sh_d   = sh_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    tag_d  = tag_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (busy_q[i]) begin
        v1_d[i]  = wv1[i];
        rs1_d[i] = wd1[i];
        v2_d[i]  = wv2[i];
        rs2_d[i] = wd2[i];
      end
    end
    if (iss_fire) busy_d[iss_idx] = 1'b0;
    if (dp_fire) begin
      busy_d[free_idx] = 1'b1;
      s1_d[free_idx]   = bus.i_dp_signed1;
      s2_d[free_idx]   = bus.i_dp_signed2;
      sh_d[free_idx]   = bus.i_dp_sel_high;
      v1_d[free_idx]   = dv1;
      v2_d[free_idx]   = dv2;
      rs1_d[free_idx]  = dd1;
      rs2_d[free_idx]  = dd2;
      tag_d[free_idx]  = bus.i_dp_rrftag;
    end
    count_d = count_q + CNT_W'(dp_fire) - CNT_W'(iss_fire);
    if (bus.i_flush) begin
      busy_d  = '0;
      v1_d    = '0;
      v2_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      sh_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rs1_q[i] <= '0;
        rs2_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      sh_q    <= sh_d;
      count_q <= count_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      tag_q   <= tag_d;
    end
  end
endmodule

// File: tb/tb_rs_mul_queue.sv
// Self-checking bench for rs_mul_queue: directed scenarios then random traffic against a reference model.
module tb_rs_mul_queue;
  import rs_mul_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned TW    = 6;
  localparam int unsigned NF    = 3;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rs_mul_queue_if #(.DATA_W(DW), .TAG_W(TW), .NUM_FWD(NF), .CNT_W(CW)) bus ();

  rs_mul_queue #(.DEPTH(DEPTH), .DATA_W(DW), .TAG_W(TW), .NUM_FWD(NF), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit            busy;
    bit            s1, s2, sh;
    bit            v1, v2;
    logic [DW-1:0] rs1, rs2;
    logic [TW-1:0] tag;
  } ent_t;

  ent_t m[DEPTH];
  bit   m_init = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // First valid channel (lowest index) carrying tag t.
  task automatic fwd_find(input logic [TW-1:0] t, output bit hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int k = 0; k < NF; k++) begin
      if (!hit && bus.i_fwd_vld[k] && bus.i_fwd_tag[k*TW +: TW] == t) begin
        hit = 1'b1;
        d   = bus.i_fwd_data[k*DW +: DW];
      end
    end
  endtask

  task automatic cmp_model();
    int   sel = -1;
    int   cnt = 0;
    bit   any_free = 1'b0;
    ent_t e = '{default: '0};
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy) cnt++;
      else any_free = 1'b1;
      if (sel < 0 && m[i].busy && m[i].v1 && m[i].v2) sel = i;
    end
    if (sel >= 0) e = m[sel];
    chk_eq("dp_rdy", bus.o_dp_rdy, any_free);
    chk_eq("count", bus.o_count, cnt);
    chk_eq("iss_vld", bus.o_iss_vld, sel >= 0);
    chk_eq("iss_rs1", bus.o_iss_rs1, e.rs1);
    chk_eq("iss_rs2", bus.o_iss_rs2, e.rs2);
    chk_eq("iss_tag", bus.o_iss_rrftag, e.tag);
    chk_eq("iss_s1", bus.o_iss_signed1, e.s1);
    chk_eq("iss_s2", bus.o_iss_signed2, e.s2);
    chk_eq("iss_sh", bus.o_iss_sel_high, e.sh);
  endtask

  task automatic settle();
    #1;
    if (m_init) cmp_model();
  endtask

  // Advance one clock and apply the same inputs to the model.
  task automatic tick();
    int   sel = -1;
    int   free = -1;
    bit   hit;
    logic [DW-1:0] d;
    ent_t n[DEPTH];
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m[i] = '{default: '0};
      m_init = 1'b1;
    end else if (m_init && bus.i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        m[i].busy = 1'b0;
        m[i].v1   = 1'b0;
        m[i].v2   = 1'b0;
      end
    end else if (m_init) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sel < 0 && m[i].busy && m[i].v1 && m[i].v2) sel = i;
        if (free < 0 && !m[i].busy) free = i;
      end
      n = m;
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].busy && !m[i].v1) begin
          fwd_find(m[i].rs1[TW-1:0], hit, d);
          if (hit) begin n[i].v1 = 1'b1; n[i].rs1 = d; end
        end
        if (m[i].busy && !m[i].v2) begin
          fwd_find(m[i].rs2[TW-1:0], hit, d);
          if (hit) begin n[i].v2 = 1'b1; n[i].rs2 = d; end
        end
      end
      if (sel >= 0 && bus.i_iss_rdy) n[sel].busy = 1'b0;
      if (bus.i_dp_vld && free >= 0) begin
        n[free].busy = 1'b1;
        n[free].s1   = bus.i_dp_signed1;
        n[free].s2   = bus.i_dp_signed2;
        n[free].sh   = bus.i_dp_sel_high;
        n[free].tag  = bus.i_dp_rrftag;
        n[free].v1   = bus.i_dp_rs1_vld;
        n[free].rs1  = bus.i_dp_rs1;
        n[free].v2   = bus.i_dp_rs2_vld;
        n[free].rs2  = bus.i_dp_rs2;
        if (!bus.i_dp_rs1_vld) begin
          fwd_find(bus.i_dp_rs1[TW-1:0], hit, d);
          if (hit) begin n[free].v1 = 1'b1; n[free].rs1 = d; end
        end
        if (!bus.i_dp_rs2_vld) begin
          fwd_find(bus.i_dp_rs2[TW-1:0], hit, d);
          if (hit) begin n[free].v2 = 1'b1; n[free].rs2 = d; end
        end
      end
      m = n;
    end
    #1;
  endtask

  task automatic idle();
    bus.i_flush       = 1'b0;
    bus.i_dp_vld      = 1'b0;
    bus.i_dp_signed1  = 1'b0;
    bus.i_dp_signed2  = 1'b0;
    bus.i_dp_sel_high = 1'b0;
    bus.i_dp_rs1_vld  = 1'b0;
    bus.i_dp_rs2_vld  = 1'b0;
    bus.i_dp_rs1      = '0;
    bus.i_dp_rs2      = '0;
    bus.i_dp_rrftag   = '0;
    bus.i_fwd_vld     = '0;
    bus.i_fwd_tag     = '0;
    bus.i_fwd_data    = '0;
  endtask

  task automatic set_dp(input bit r1v, input logic [DW-1:0] r1, input bit r2v,
                        input logic [DW-1:0] r2, input logic [TW-1:0] t);
    bus.i_dp_vld      = 1'b1;
    bus.i_dp_rs1_vld  = r1v;
    bus.i_dp_rs1      = r1;
    bus.i_dp_rs2_vld  = r2v;
    bus.i_dp_rs2      = r2;
    bus.i_dp_rrftag   = t;
    bus.i_dp_signed1  = 1'($urandom_range(0, 1));
    bus.i_dp_signed2  = 1'($urandom_range(0, 1));
    bus.i_dp_sel_high = 1'($urandom_range(0, 1));
  endtask

  task automatic set_fwd(input int ch, input logic [TW-1:0] t, input logic [DW-1:0] d);
    bus.i_fwd_vld[ch]          = 1'b1;
    bus.i_fwd_tag[ch*TW +: TW] = t;
    bus.i_fwd_data[ch*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rand_opnd(input bit vld);
    logic [DW-1:0] v = $urandom;
    if (!vld) v[TW-1:0] = TW'($urandom_range(0, 7));
    return v;
  endfunction

  task automatic rand_inputs();
    bit r1v = 1'($urandom_range(0, 1));
    bit r2v = 1'($urandom_range(0, 1));
    idle();
    rst_n         = ($urandom_range(0, 99) != 0);
    bus.i_flush   = ($urandom_range(0, 99) < 3);
    bus.i_iss_rdy = ($urandom_range(0, 9) < 6);
    if ($urandom_range(0, 9) < 6)
      set_dp(r1v, rand_opnd(r1v), r2v, rand_opnd(r2v), TW'($urandom));
    for (int k = 0; k < NF; k++)
      if ($urandom_range(0, 9) < 4) set_fwd(k, TW'($urandom_range(0, 7)), $urandom);
  endtask

  initial begin
    idle();
    bus.i_iss_rdy = 1'b0;
    rst_n = 1'b0;
    tick();
    settle();
    chk_eq("rst_dp_rdy", bus.o_dp_rdy, 1);
    chk_eq("rst_iss_vld", bus.o_iss_vld, 0);
    chk_eq("rst_count", bus.o_count, 0);
    chk_eq("rst_iss_rs1", bus.o_iss_rs1, 0);
    tick();
    rst_n = 1'b1;

    // Both operands ready at dispatch.
    set_dp(1, 5, 1, 7, 3);
    bus.i_iss_rdy = 1'b1;
    settle();
    tick();
    idle();
    settle();
    chk_eq("d1_vld", bus.o_iss_vld, 1);
    chk_eq("d1_rs1", bus.o_iss_rs1, 5);
    chk_eq("d1_rs2", bus.o_iss_rs2, 7);
    chk_eq("d1_tag", bus.o_iss_rrftag, 3);
    tick();
    settle();
    chk_eq("d1_count", bus.o_count, 0);

    // Late wakeup of rs1 on channel 1.
    bus.i_iss_rdy = 1'b0;
    set_dp(0, 9, 1, 2, 10);
    settle();
    tick();
    idle();
    set_fwd(1, 9, 32'h10);
    settle();
    chk_eq("d2_nowake", bus.o_iss_vld, 0);
    tick();
    idle();
    settle();
    chk_eq("d2_vld", bus.o_iss_vld, 1);
    chk_eq("d2_rs1", bus.o_iss_rs1, 32'h10);
    chk_eq("d2_rs2", bus.o_iss_rs2, 2);
    bus.i_iss_rdy = 1'b1;
    settle();
    tick();

    // Dispatch bypass of a same-cycle broadcast.
    bus.i_iss_rdy = 1'b0;
    set_dp(1, 32'h33, 0, 4, 11);
    set_fwd(0, 4, 32'hAB);
    settle();
    tick();
    idle();
    settle();
    chk_eq("d3_vld", bus.o_iss_vld, 1);
    chk_eq("d3_rs2", bus.o_iss_rs2, 32'hAB);
    bus.i_iss_rdy = 1'b1;
    settle();
    tick();
    bus.i_iss_rdy = 1'b0;

    // Fill, ignored dispatch when full, then concurrent issue and dispatch.
    for (int i = 0; i < DEPTH; i++) begin
      set_dp(1, DW'(i + 1), 1, DW'(i + 2), TW'(i + 20));
      settle();
      tick();
    end
    idle();
    settle();
    chk_eq("full_dp_rdy", bus.o_dp_rdy, 0);
    chk_eq("full_count", bus.o_count, DEPTH);
    set_dp(1, 99, 1, 98, 30);
    settle();
    tick();
    settle();
    chk_eq("full_ignored", bus.o_count, DEPTH);
    bus.i_iss_rdy = 1'b1;
    settle();
    tick();
    settle();
    chk_eq("full_iss_only", bus.o_count, DEPTH - 1);
    tick();
    settle();
    chk_eq("iss_and_dp", bus.o_count, DEPTH - 1);

    // Flush with a dispatch attempt.
    bus.i_iss_rdy = 1'b0;
    bus.i_flush   = 1'b1;
    settle();
    tick();
    idle();
    settle();
    chk_eq("flush_count", bus.o_count, 0);
    chk_eq("flush_iss_vld", bus.o_iss_vld, 0);
    chk_eq("flush_dp_rdy", bus.o_dp_rdy, 1);

    for (int c = 0; c < 800; c++) begin
      rand_inputs();
      settle();
      tick();
    end
    rst_n = 1'b1;
    idle();
    bus.i_iss_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
